// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Purpose : Bundles the execute-stage handshake and the HI/LO result bus of
//           the DIV/DIVU sequencer so the pipeline and the sequencer share
//           one connection.
// Ports   : start_i, signed_i, a_i, b_i, cancel_i  - execute stage -> sequencer
//           stall_o, ready_o, hilowrite_o, hi_o, lo_o - sequencer -> pipeline
// Modports: master = execute stage / pipeline side, slave = sequencer side.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             stall_o;
    logic             ready_o;
    logic             hilowrite_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, a_i, b_i, cancel_i,
        input  stall_o, ready_o, hilowrite_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, cancel_i,
        output stall_o, ready_o, hilowrite_o, hi_o, lo_o
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
// Purpose : Multi-cycle DIV/DIVU unit for the five-stage MIPS pipeline.
//           Radix-2 restoring division, one quotient bit per clock. Holds
//           the front of the pipeline with stall_o while it works, then
//           presents remainder (HI) and quotient (LO) with a one-cycle
//           write strobe.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous, active-low reset
//           bus  - div_sequencer_if.slave (operands, cancel, stall, results)
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    div_sequencer_if.slave   bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             quo_neg;
    logic             rem_neg;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             do_load;
    logic             do_zero;
    logic             do_iter;
    logic             do_commit;

    // Operand magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly its magnitude, so no extra bit is needed.
    always_comb begin
        a_mag = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
        b_mag = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
    end

    // One restoring step. The trial value is one bit wider than the
    // remainder so the top bit of the difference acts as the borrow.
    // Since the kept remainder is always below the divisor, a failed trial
    // never has its top bit set and can be truncated safely.
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end
        quo_fixed = quo_neg ? -quo_step : quo_step;
        rem_fixed = rem_neg ? -rem_step : rem_step;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control. A flush beats everything, including
    // the final iteration, so a cancelled divide never commits.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_zero    = 1'b0;
        do_iter    = 1'b0;
        do_commit  = 1'b0;
        if (bus.cancel_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.b_i == '0) begin
                            state_next = DONE;
                            do_zero    = 1'b1;
                        end else begin
                            state_next = RUN;
                            do_load    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    do_iter = 1'b1;
                    if (count == LAST) begin
                        state_next = DONE;
                        do_commit  = 1'b1;
                    end
                end
                DONE: begin
                    // The instruction that launched us is still in execute,
                    // so a start seen here is the same DIV and is ignored.
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath: operand latch, iteration, and the committed HI/LO values.
    // HI/LO only change on entry to DONE, so a flush leaves them intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (do_load) begin
                count   <= '0;
                rem     <= '0;
                quo     <= a_mag;
                divisor <= b_mag;
                quo_neg <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                rem_neg <= bus.signed_i & bus.a_i[WIDTH-1];
            end
            if (do_iter) begin
                rem   <= rem_step;
                quo   <= quo_step;
                count <= count + 1'b1;
            end
            if (do_commit) begin
                lo <= quo_fixed;
                hi <= rem_fixed;
            end
            // Divide by zero never traps; HI returns the raw dividend.
            if (do_zero) begin
                lo <= '1;
                hi <= bus.a_i;
            end
        end
    end

    assign bus.stall_o     = ((state == IDLE) && bus.start_i && !bus.cancel_i) || (state == RUN);
    assign bus.ready_o     = (state == DONE);
    assign bus.hilowrite_o = (state == DONE);
    assign bus.hi_o        = hi;
    assign bus.lo_o        = lo;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Purpose : Self-checking bench for div_sequencer. A table of directed
//           divides with hand-computed results, plus hand-written sequences
//           for flush, back-to-back start and mid-run reset.
// Ports   : none (top-level bench)
module tb_div_sequencer;
    localparam int WIDTH = 32;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   failures;
    logic [31:0] last_lo;
    logic [31:0] last_hi;
    vec_t vecs [12];

    div_sequencer_if #(.WIDTH(WIDTH)) bus ();

    div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any hang in the DUT ends the run here.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one divide from IDLE and follow it to its strobe.
    task automatic apply_stimulus(input string name, input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   cyc;
        int   exp_lat;
        logic stall_ok;
        exp_lat      = (b == 32'd0) ? 1 : WIDTH + 1;
        bus.start_i  = 1'b1;
        bus.signed_i = sgn;
        bus.a_i      = a;
        bus.b_i      = b;
        #4;
        check_output({name, " stall_at_start"}, 32'(bus.stall_o), 32'd1);
        step();
        bus.start_i = 1'b0;
        cyc         = 1;
        stall_ok    = 1'b1;
        while (!bus.ready_o && cyc < 80) begin
            if (!bus.stall_o) stall_ok = 1'b0;
            step();
            cyc++;
        end
        check_output({name, " stall_during_run"}, 32'(stall_ok), 32'd1);
        check_output({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check_output({name, " hilowrite"}, 32'(bus.hilowrite_o), 32'd1);
        check_output({name, " stall_in_done"}, 32'(bus.stall_o), 32'd0);
        check_output({name, " lo"}, bus.lo_o, exp_lo);
        check_output({name, " hi"}, bus.hi_o, exp_hi);
        step();
        check_output({name, " ready_after"}, 32'(bus.ready_o), 32'd0);
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        int strobes;
        int first_cyc;
        int second_cyc;
        logic quiet;

        tests    = 0;
        failures = 0;
        last_lo  = 32'd0;
        last_hi  = 32'd0;

        vecs[0]  = '{"divu_100_7",     1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
        vecs[1]  = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[2]  = '{"div_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1};
        vecs[3]  = '{"div_min_m1",     1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0};
        vecs[4]  = '{"divu_5_0",       1'b0, 32'd5,          32'd0,        32'hFFFFFFFF,  32'd5};
        vecs[5]  = '{"div_m5_0",       1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,  32'hFFFFFFFB};
        vecs[6]  = '{"div_m7_m2",      1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,         32'hFFFFFFFF};
        vecs[7]  = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0};
        vecs[8]  = '{"divu_7_100",     1'b0, 32'd7,          32'd100,      32'd0,         32'd7};
        vecs[9]  = '{"divu_max_max",   1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,         32'd0};
        vecs[10] = '{"divu_min_max",   1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,         32'h80000000};
        vecs[11] = '{"div_100_7",      1'b1, 32'd100,        32'd7,        32'd14,        32'd2};

        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.cancel_i = 1'b0;
        rst          = 1'b0;

        // Reset state.
        #3;
        check_output("reset stall", 32'(bus.stall_o), 32'd0);
        check_output("reset ready", 32'(bus.ready_o), 32'd0);
        check_output("reset hilowrite", 32'(bus.hilowrite_o), 32'd0);
        check_output("reset hi", bus.hi_o, 32'd0);
        check_output("reset lo", bus.lo_o, 32'd0);
        #9;
        rst = 1'b1;
        step();

        // Table of directed divides.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
        end

        // Flush in RUN cycle 10: back to IDLE, no strobe, HI/LO untouched.
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.a_i      = 32'd100;
        bus.b_i      = 32'd7;
        step();
        bus.start_i = 1'b0;
        repeat (9) step();
        bus.cancel_i = 1'b1;
        step();
        bus.cancel_i = 1'b0;
        check_output("cancel stall", 32'(bus.stall_o), 32'd0);
        check_output("cancel ready", 32'(bus.ready_o), 32'd0);
        check_output("cancel lo", bus.lo_o, last_lo);
        check_output("cancel hi", bus.hi_o, last_hi);
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.hilowrite_o || bus.stall_o) quiet = 1'b0;
            step();
        end
        check_output("cancel no_strobe", 32'(quiet), 32'd1);
        apply_stimulus("after_cancel_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // start_i held through DONE: ignored there, accepted in the IDLE after.
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.a_i      = 32'd100;
        bus.b_i      = 32'd7;
        strobes      = 0;
        first_cyc    = -1;
        second_cyc   = -1;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (bus.hilowrite_o) begin
                strobes++;
                if (strobes == 1) begin
                    first_cyc = c;
                    check_output("b2b first lo", bus.lo_o, 32'd14);
                    check_output("b2b first hi", bus.hi_o, 32'd2);
                    bus.a_i = 32'd20;
                    bus.b_i = 32'd6;
                end else if (strobes == 2) begin
                    second_cyc = c;
                    check_output("b2b second lo", bus.lo_o, 32'd3);
                    check_output("b2b second hi", bus.hi_o, 32'd2);
                end
            end
            if (first_cyc > 0 && c == first_cyc + 1) begin
                check_output("b2b idle stall", 32'(bus.stall_o), 32'd1);
            end
            if (first_cyc > 0 && c == first_cyc + 2) begin
                bus.start_i = 1'b0;
            end
        end
        check_output("b2b strobes", 32'(strobes), 32'd2);
        check_output("b2b first cycle", 32'(first_cyc), 32'd33);
        check_output("b2b second cycle", 32'(second_cyc), 32'd67);
        last_lo = 32'd3;
        last_hi = 32'd2;

        // Asynchronous reset in RUN cycle 15.
        bus.start_i = 1'b1;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        step();
        bus.start_i = 1'b0;
        repeat (14) step();
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst stall", 32'(bus.stall_o), 32'd0);
        check_output("midrst ready", 32'(bus.ready_o), 32'd0);
        check_output("midrst hilowrite", 32'(bus.hilowrite_o), 32'd0);
        check_output("midrst hi", bus.hi_o, 32'd0);
        check_output("midrst lo", bus.lo_o, 32'd0);
        step();
        step();
        #3;
        rst = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.hilowrite_o || bus.stall_o || bus.ready_o) quiet = 1'b0;
        end
        check_output("midrst stays_idle", 32'(quiet), 32'd1);
        apply_stimulus("after_reset_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for DIV/DIVU in the five-stage MIPS pipeline. It accepts operands from the execute stage and runs a radix-2 restoring division, one quotient bit per cycle. While it runs it holds the pipeline through a stall request. On completion it presents the quotient and remainder with a one-cycle write strobe, so the HI/LO register file captures them (remainder to HI, quotient to LO).

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  execute stage holds a DIV/DIVU; sampled only in IDLE.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- a_i  input  WIDTH  dividend (forwarded rs value).
- b_i  input  WIDTH  divisor (forwarded rt value).
- cancel_i  input  1  flush of the execute stage; aborts any operation.
- stall_o  output  1  hold fetch/decode/execute; combinational.
- ready_o  output  1  results valid this cycle.
- hilowrite_o  output  1  write strobe to HI/LO; equals ready_o.
- hi_o  output  WIDTH  remainder.
- lo_o  output  WIDTH  quotient.

## Operation
States:
- IDLE: wait for start_i.
- RUN: iterate.
- DONE: present results.

Transitions:
- IDLE → RUN: start_i=1, cancel_i=0, b_i≠0.
  - Latch |a_i|, |b_i| (abs only when signed_i=1).
  - Latch quotient sign = a[W-1]^b[W-1] and remainder sign = a[W-1] (signed only).
  - Clear partial remainder; count=0.
- IDLE → DONE, divide by zero: start_i=1, cancel_i=0, b_i==0.
  - Load lo = all ones and hi = a_i unmodified, for both signed and unsigned.
- RUN, each cycle:
  - Shift {rem,quo} left by 1 and trial-subtract the divisor.
  - If the difference is non-negative, keep it and set the quotient LSB to 1.
  - count++.
  - count==WIDTH-1 → DONE; on this final transition apply sign fix: negate the quotient if its sign bit is set, negate the remainder if the dividend was negative.
- DONE → IDLE unconditionally. start_i in DONE is ignored, because the same instruction is still in execute.
- cancel_i=1 in any state → IDLE at the next edge; no strobe is issued; hi_o/lo_o keep their last committed values. cancel_i has priority over start_i.

Outputs:
- stall_o = (IDLE & start_i & ~cancel_i) | RUN.
- stall_o is 0 in DONE, letting the instruction advance as HI/LO are written.
- hi_o/lo_o are registered. They update only on entry to DONE and hold until the next DONE.

Arithmetic:
- Internal remainder is WIDTH+1 bits (carry/borrow bit).
- Signed 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (wrap, no trap).

## Timing
- Reset (rst=0, asynchronous): state=IDLE, count=0, stall_o=0, ready_o=0, hilowrite_o=0, hi_o=0, lo_o=0.
- Normal latency, with start accepted in cycle t:
  - RUN in cycles t+1 … t+WIDTH.
  - DONE in t+WIDTH+1 (t+33 for WIDTH=32), with ready_o=hilowrite_o=1 for exactly 1 cycle.
  - stall_o=1 in cycles t … t+WIDTH.
- Divide by zero: DONE in t+1; stall_o=1 only in cycle t.
- Back-to-back: a new start_i in the cycle after DONE (IDLE) is accepted normally. There are no idle bubbles beyond DONE.
- Reset asserted mid-RUN: immediate IDLE, no strobe. Operation resumes only with a fresh start_i after reset deasserts.

## Test plan
- DIVU 100/7, start at cycle 0 → stall_o high cycles 0–32; cycle 33 ready_o=hilowrite_o=1, lo_o=14, hi_o=2; cycle 34 IDLE, ready_o=0.
- DIV -7/2 (0xFFFFFFF9/0x2) → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/-2 → lo_o=0xFFFFFFFD, hi_o=1.
- DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0; DIVU 5/0 → DONE at cycle 1, lo_o=0xFFFFFFFF, hi_o=5.
- Start 100/7; assert cancel_i in RUN cycle 10 → IDLE at cycle 11, stall_o=0, no hilowrite_o, hi_o/lo_o unchanged. Then start 9/3 → lo_o=3, hi_o=0, 33 cycles later.
- Hold start_i high through DONE and on into the next cycle, with new operands 20/6 → first result strobes once; the second operation starts in the IDLE cycle after DONE; exactly two strobes, the second lo_o=3, hi_o=2.
- Drop rst to 0 at RUN cycle 15 → all outputs 0 immediately; after release the block stays IDLE until start_i.
